// File: rtl/alu_input_seq.sv
// rtl/alu_input_seq.sv - push-button operand/opcode entry sequencer for the 8-bit ALU
//
// Build option: define ALU_SEQ_DEBOUNCE_EN to enable the key debounce filter;
// without it every synchronised falling edge of key_n is a press.
//
// Ports:
//   CLOCK_50      sole clock, rising edge
//   reset         synchronous active-high reset
//   key_n         active-low push-button, asynchronous
//   sw_data       operand switches
//   sw_op         opcode switches
//   alu_result    ALU combinational result
//   alu_ovf       ALU overflow flag
//   alu_br        ALU compare flag
//   op_a, op_b    registered operands to the ALU
//   opcode        registered opcode to the ALU
//   op_valid      one-cycle execute strobe (high during S_EXEC)
//   result_q      latched result
//   ovf_q, br_q   latched flags
//   result_valid  high while in S_SHOW
//   state         FSM state encoding for LED debug
module alu_input_seq #(
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [2:0]        sw_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  input  logic              alu_br,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        opcode,
  output logic              op_valid,
  output logic [DATA_W-1:0] result_q,
  output logic              ovf_q,
  output logic              br_q,
  output logic              result_valid,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t st;
  logic   key_m;
  logic   key_s;
  logic   fall;
  logic   press;

  assign state = st;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             key_db;
  logic             key_db_d;

  // key_db follows key_s only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      db_cnt   <= '0;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
    end else begin
      key_db_d <= key_db;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign fall = key_db_d & ~key_db;
`else
  logic key_s_d;
  logic unused_cfg;

  // Debounce length has no effect in this build.
  assign unused_cfg = (DEBOUNCE_CYC < 2);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s_d <= 1'b1;
    end else begin
      key_s_d <= key_s;
    end
  end

  assign fall = key_s_d & ~key_s;
`endif

  // Press pulse is one cycle wide; releases produce nothing.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      press <= 1'b0;
    end else begin
      press <= fall;
    end
  end

  // op_valid and result_valid are registered so they line up with S_EXEC / S_SHOW.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st           <= S_A;
      op_a         <= '0;
      op_b         <= '0;
      opcode       <= '0;
      op_valid     <= 1'b0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      br_q         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      case (st)
        S_A: begin
          if (press) begin
            op_a <= sw_data;
            st   <= S_B;
          end
        end
        S_B: begin
          if (press) begin
            op_b <= sw_data;
            st   <= S_OP;
          end
        end
        S_OP: begin
          if (press) begin
            opcode   <= sw_op;
            op_valid <= 1'b1;
            st       <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Compare opcodes (11x) report only br; the result is forced to zero.
          result_q     <= (opcode[2:1] == 2'b11) ? '0 : alu_result;
          ovf_q        <= ((opcode == 3'd0) || (opcode == 3'd3)) ? alu_ovf : 1'b0;
          br_q         <= (opcode[2:1] == 2'b11) ? alu_br : 1'b0;
          result_valid <= 1'b1;
          st           <= S_SHOW;
        end
        S_SHOW: begin
          if (press) begin
            result_valid <= 1'b0;
            st           <= S_A;
          end
        end
        default: begin
          result_valid <= 1'b0;
          st           <= S_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_input_seq.sv
// tb/tb_alu_input_seq.sv - self-checking bench for alu_input_seq
module tb_alu_input_seq;

  localparam int DW = 8;
  localparam int DC = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int PL = DC + 3;
  localparam bit DB = 1'b1;
`else
  localparam int PL = 3;
  localparam bit DB = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          key_n;
  logic [DW-1:0] sw_data;
  logic [2:0]    sw_op;
  logic [DW-1:0] alu_result;
  logic          alu_ovf;
  logic          alu_br;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [2:0]    opcode;
  logic          op_valid;
  logic [DW-1:0] result_q;
  logic          ovf_q;
  logic          br_q;
  logic          result_valid;
  logic [2:0]    state;

  always #10 CLOCK_50 = ~CLOCK_50;

  alu_input_seq #(.DATA_W(DW), .DEBOUNCE_CYC(DC)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n),
    .sw_data(sw_data), .sw_op(sw_op),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_br(alu_br),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .op_valid(op_valid),
    .result_q(result_q), .ovf_q(ovf_q), .br_q(br_q),
    .result_valid(result_valid), .state(state)
  );

  // Stand-in ALU; flags are deliberately 1 on opcodes where they must be masked.
  logic [DW-1:0] alu_tmp;
  always_comb begin
    alu_tmp    = '0;
    alu_result = '0;
    alu_ovf    = 1'b1;
    alu_br     = 1'b1;
    case (opcode)
      3'd0: begin
        alu_tmp    = op_a + op_b;
        alu_result = alu_tmp;
        alu_ovf    = (op_a[7] == op_b[7]) && (alu_tmp[7] != op_a[7]);
      end
      3'd1: alu_result = op_a & op_b;
      3'd2: alu_result = op_a | op_b;
      3'd3: begin
        alu_tmp    = op_a - op_b;
        alu_result = alu_tmp;
        alu_ovf    = (op_a[7] != op_b[7]) && (alu_tmp[7] != op_a[7]);
      end
      3'd4: alu_result = op_a ^ op_b;
      3'd5: alu_result = ~op_a;
      3'd6: begin
        alu_result = op_a | 8'h5A;
        alu_br     = (op_a == op_b);
      end
      default: begin
        alu_result = 8'hA5;
        alu_br     = (op_a > op_b);
      end
    endcase
  end

  int ov_cnt = 0;
  always @(negedge CLOCK_50) if (op_valid) ov_cnt <= ov_cnt + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press_key();
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  // Reference: captured {result, ovf, br} from plain signed/unsigned arithmetic.
  task automatic model(input int a, input int b, input int op,
                       output logic [7:0] r, output logic o, output logic br);
    int sa, sb, t;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = 8'h00; o = 1'b0; br = 1'b0;
    case (op)
      0: begin r = 8'((a + b) % 256); t = sa + sb; o = (t > 127) || (t < -128); end
      1: r = 8'(a & b);
      2: r = 8'(a | b);
      3: begin r = 8'((a - b + 256) % 256); t = sa - sb; o = (t > 127) || (t < -128); end
      4: r = 8'(a ^ b);
      5: r = 8'(255 - a);
      6: br = (a == b);
      default: br = (a > b);
    endcase
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       ovf;
    logic       br;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int ov0;
    int st0;
    vecs[0] = '{8'h12, 8'h34, 3'd0, 8'h46, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 8'h55, 3'd6, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'h56, 8'h55, 3'd7, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h70, 8'h20, 3'd0, 8'h90, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 3'd3, 8'h7F, 1'b1, 1'b0};
    vecs[5] = '{8'hF0, 8'h3C, 3'd1, 8'h30, 1'b0, 1'b0};
    vecs[6] = '{8'h54, 8'h55, 3'd6, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h0F, 8'hF0, 3'd5, 8'hF0, 1'b0, 1'b0};
    vecs[8] = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h10, 8'h20, 3'd7, 8'h00, 1'b0, 1'b0};
    for (int i = 10; i < 16; i++) begin
      vecs[i].a  = 8'($urandom_range(0, 255));
      vecs[i].b  = 8'($urandom_range(0, 255));
      vecs[i].op = 3'($urandom_range(0, 7));
      model(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].op),
            vecs[i].res, vecs[i].ovf, vecs[i].br);
    end

    reset = 1'b1; key_n = 1'b1; sw_data = '0; sw_op = '0;
    tick(2);
    check("rst_state", state, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_opcode", opcode, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_result_q", result_q, 0);
    check("rst_ovf_q", ovf_q, 0);
    check("rst_br_q", br_q, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_no_strobe", ov_cnt, 0);
    reset = 1'b0;
    tick(2);

    // Key held 10 cycles: press after edge PL, state moves at edge PL+1.
    sw_data = 8'h12;
    key_n = 1'b0;
    tick(PL);
    check("lat_before", state, 0);
    tick(1);
    check("lat_after", state, 1);
    check("lat_op_a", op_a, 8'h12);
    tick(10 - PL - 1);
    key_n = 1'b1;
    tick(12);
    check("held_single", state, 1);

    // Short low pulse: rejected by the filter, counted without it.
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(12);
    check("glitch", state, DB ? 1 : 2);

    // Bounce low/high/low then held.
    do_reset();
    key_n = 1'b0; tick(1);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(10);
    key_n = 1'b1; tick(12);
    check("bounce", state, DB ? 1 : 2);

    // Reset mid-operation with key low and debounce in progress.
    do_reset();
    sw_data = 8'h12; press_key();
    sw_data = 8'h34; press_key();
    check("mid_pre_state", state, 2);
    key_n = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("mid_state", state, 0);
    check("mid_op_a", op_a, 0);
    check("mid_op_b", op_b, 0);
    reset = 1'b0;
    sw_data = 8'h77;
    tick(PL);
    check("mid_held_before", state, 0);
    tick(1);
    check("mid_held_after", state, 1);
    check("mid_held_op_a", op_a, 8'h77);
    key_n = 1'b1;
    tick(12);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      ov0 = ov_cnt;
      sw_data = vecs[i].a; press_key();
      sw_data = vecs[i].b; press_key();
      sw_op = vecs[i].op;  press_key();
      check($sformatf("v%0d_strobe", i), ov_cnt - ov0, 1);
      check($sformatf("v%0d_state", i), state, 4);
      check($sformatf("v%0d_rvalid", i), result_valid, 1);
      check($sformatf("v%0d_op_a", i), op_a, vecs[i].a);
      check($sformatf("v%0d_op_b", i), op_b, vecs[i].b);
      check($sformatf("v%0d_opcode", i), opcode, vecs[i].op);
      check($sformatf("v%0d_result", i), result_q, vecs[i].res);
      check($sformatf("v%0d_ovf", i), ovf_q, vecs[i].ovf);
      check($sformatf("v%0d_br", i), br_q, vecs[i].br);
      st0 = ov_cnt;
      sw_data = ~vecs[i].a;
      press_key();
      check($sformatf("v%0d_back_state", i), state, 0);
      check($sformatf("v%0d_back_rvalid", i), result_valid, 0);
      check($sformatf("v%0d_back_result", i), result_q, vecs[i].res);
      check($sformatf("v%0d_back_op_a", i), op_a, vecs[i].a);
      check($sformatf("v%0d_back_strobe", i), ov_cnt - st0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_input_seq.md
# alu_input_seq

Operand-entry sequencer that sits directly upstream of the 8-bit combinational ALU on the DE1 board. The user steps through A, B and opcode entry with one push-button. Operands are captured from the switches into registers and presented to the ALU. A one-cycle execute strobe is issued, and the ALU result and flags are latched for display on LEDR/HEX. Button input is synchronised and debounced inside the block.

## Interface

Parameters:
- DATA_W, 8, operand/result width.
- DEBOUNCE_CYC, 500000, consecutive stable synchronised samples needed to accept a key level change. Use 4 in simulation. Must be ≥ 2.

Ports:
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; sampled on CLOCK_50 rising edge.
- key_n  in  1  push-button, active-low, asynchronous to CLOCK_50.
- sw_data  in  DATA_W  operand value from switches.
- sw_op  in  3  opcode from switches.
- alu_result  in  DATA_W  ALU combinational result.
- alu_ovf  in  1  ALU overflow flag.
- alu_br  in  1  ALU compare flag.
- op_a  out  DATA_W  registered operand A to ALU.
- op_b  out  DATA_W  registered operand B to ALU.
- opcode  out  3  registered opcode to ALU.
- op_valid  out  1  one-cycle execute strobe.
- result_q  out  DATA_W  latched result.
- ovf_q  out  1  latched overflow.
- br_q  out  1  latched compare flag.
- result_valid  out  1  high while in S_SHOW.
- state  out  3  current FSM state encoding, for LED debug.

## Operation

- **Synchroniser:** two flops on key_n giving key_s. Both flops reset to 1 (released).
- **Debounce:**
  - key_db resets to 1.
  - The counter clears whenever key_s == key_db.
  - It increments on each edge where key_s != key_db.
  - On the DEBOUNCE_CYC-th consecutive differing edge, key_db takes key_s and the counter clears.
- **Press event:** press is a registered one-cycle pulse, set on the edge after key_db goes 1→0. Release (0→1) generates nothing.
- **FSM, encoded 0–4:**
  - S_A(0): on press, op_a ← sw_data, go to S_B.
  - S_B(1): on press, op_b ← sw_data, go to S_OP.
  - S_OP(2): on press, opcode ← sw_op, go to S_EXEC.
  - S_EXEC(3): op_valid = 1 for exactly this cycle. At the closing edge, capture the ALU outputs as in the rules below, then go to S_SHOW unconditionally. A press during S_EXEC is ignored.
  - S_SHOW(4): result_valid = 1. On press, go to S_A. op_a, op_b, opcode and the result registers hold.
  - Illegal encodings (5–7) go to S_A on the next edge.
- **Capture rules in S_EXEC:**
  - result_q ← alu_result for opcodes 000–101; result_q ← 0 for 110 and 111.
  - ovf_q ← alu_ovf for opcodes 000 and 011; otherwise 0.
  - br_q ← alu_br for opcodes 110 and 111; otherwise 0.
- **Switch sampling:** switch inputs are sampled only on the accepting edge; values in between are don't-care.
- **Reset values:** every output is 0 and state = S_A. Debounce counter = 0, key_db = 1, press = 0.

## Timing

- **Debounce latency:** key_n first sampled low at edge 1 and held low → press is high for exactly one cycle after edge DEBOUNCE_CYC+3.
- **Glitch rejection:** a low pulse shorter than DEBOUNCE_CYC synchronised samples produces no press.
- **Key held:** produces exactly one press. A new press requires a debounced release first.
- **Execute latency:** opcode-accepting edge → op_valid high for the next cycle → result_q valid and result_valid high after the following edge.
- **ALU path:** combinational only within one cycle; op_a, op_b and opcode are stable for the whole S_EXEC cycle.
- **Reset mid-operation:** the next edge restores all reset values, including any debounce count in progress. A key held low through reset yields one press DEBOUNCE_CYC+3 edges after reset deasserts.
- **Reset and press on the same edge:** reset wins.

## Configuration

- **ALU_SEQ_DEBOUNCE_EN defined:** debounce filter as specified above.
- **ALU_SEQ_DEBOUNCE_EN undefined:**
  - The debounce counter and key_db are removed, and DEBOUNCE_CYC is ignored.
  - press is a registered pulse on a key_s 1→0 transition, high for one cycle after edge 3 when key_n is first sampled low at edge 1.
  - Every synchronised falling edge counts, including bounces.

## Test plan

All scenarios use DEBOUNCE_CYC = 4 and the real ALU connected, with the macro defined unless stated.

- **Reset:** hold reset 2 cycles → all outputs 0, state = 0, op_valid never asserted.
- **Add:** sw_data 0x12 press, 0x34 press, sw_op 000 press → op_valid exactly one cycle; result_q = 0x46; state = 4; result_valid = 1; op_a = 0x12; op_b = 0x34.
- **Compare:** A = 0x55, B = 0x55, op 110 → br_q = 1, result_q = 0x00, ovf_q = 0. A = 0x56, B = 0x55, op 111 → br_q = 1.
- **Glitch:** key_n low for 3 cycles, then high → no press, state unchanged. Key low for 10 cycles → single press after edge 7, state advances by exactly 1.
- **Mid-operation reset:** reset asserted in S_OP with op_a = 0x12 → after the next edge, state = 0, op_a = 0, op_b = 0, counter cleared.
- **Macro undefined:** key low at edge 1 → press high after edge 3. A 2-cycle bounce (low, high, low) → two presses, and state advances by 2.
